// File: rtl/rs_branch.sv
// Branch reservation station: a collapsing age-ordered queue that issues the oldest entry whose operands are ready.
// Optional statistics counters are enabled by defining RS_BRANCH_STATS_EN.
module rs_branch #(
    parameter int DEPTH  = 4,
    parameter int PREG_W = 6,
    parameter int ROB_W  = 5,
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_valid,
    input  logic [OP_W-1:0]   alloc_op,
    input  logic [ROB_W-1:0]  alloc_rob,
    input  logic [DATA_W-1:0] alloc_pc,
    input  logic [DATA_W-1:0] alloc_imm,
    input  logic [PREG_W-1:0] alloc_s1_tag,
    input  logic [PREG_W-1:0] alloc_s2_tag,
    input  logic              alloc_s1_rdy,
    input  logic              alloc_s2_rdy,
    input  logic [DATA_W-1:0] alloc_s1_val,
    input  logic [DATA_W-1:0] alloc_s2_val,
    input  logic              cdb_valid,
    input  logic [PREG_W-1:0] cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              issue_ready,
    output logic              issue_valid,
    output logic [OP_W-1:0]   issue_op,
    output logic [ROB_W-1:0]  issue_rob,
    output logic [DATA_W-1:0] issue_pc,
    output logic [DATA_W-1:0] issue_imm,
    output logic [DATA_W-1:0] issue_s1,
    output logic [DATA_W-1:0] issue_s2,
    output logic              RSBRA_full,
    input  logic              RSBRA_rollback,
    output logic [31:0]       stat_full_cycles,
    output logic [31:0]       stat_issued
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    typedef struct packed {
        logic              vld;
        logic [OP_W-1:0]   op;
        logic [ROB_W-1:0]  rob;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] imm;
        logic [PREG_W-1:0] s1_tag;
        logic              s1_rdy;
        logic [DATA_W-1:0] s1_val;
        logic [PREG_W-1:0] s2_tag;
        logic              s2_rdy;
        logic [DATA_W-1:0] s2_val;
    } entry_t;

    entry_t           q     [DEPTH];
    entry_t           woke  [DEPTH];
    entry_t           nxt   [DEPTH];
    entry_t           new_entry;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] base;
    logic [IDX_W-1:0] sel;
    logic             fire;
    logic             alloc_ok;

    // Scan from the youngest down so the oldest ready entry wins the select.
    always_comb begin
        issue_valid = 1'b0;
        sel         = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (q[i].vld && q[i].s1_rdy && q[i].s2_rdy) begin
                issue_valid = 1'b1;
                sel         = IDX_W'(i);
            end
        end
    end

    assign issue_op   = q[sel].op;
    assign issue_rob  = q[sel].rob;
    assign issue_pc   = q[sel].pc;
    assign issue_imm  = q[sel].imm;
    assign issue_s1   = q[sel].s1_val;
    assign issue_s2   = q[sel].s2_val;
    assign RSBRA_full = (cnt == CNT_W'(DEPTH));
    assign fire       = issue_valid & issue_ready;
    assign alloc_ok   = alloc_valid & ~RSBRA_full;

    // Incoming entry, with a source caught directly off the CDB when it is broadcast at dispatch.
    always_comb begin
        new_entry        = '0;
        new_entry.vld    = 1'b1;
        new_entry.op     = alloc_op;
        new_entry.rob    = alloc_rob;
        new_entry.pc     = alloc_pc;
        new_entry.imm    = alloc_imm;
        new_entry.s1_tag = alloc_s1_tag;
        new_entry.s1_rdy = alloc_s1_rdy;
        new_entry.s1_val = alloc_s1_val;
        new_entry.s2_tag = alloc_s2_tag;
        new_entry.s2_rdy = alloc_s2_rdy;
        new_entry.s2_val = alloc_s2_val;
        if (cdb_valid && !alloc_s1_rdy && (alloc_s1_tag == cdb_tag)) begin
            new_entry.s1_rdy = 1'b1;
            new_entry.s1_val = cdb_data;
        end
        if (cdb_valid && !alloc_s2_rdy && (alloc_s2_tag == cdb_tag)) begin
            new_entry.s2_rdy = 1'b1;
            new_entry.s2_val = cdb_data;
        end
    end

    // Next state: wakeup, then collapse over the issued slot, then append at the new tail.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woke[i] = q[i];
            if (cdb_valid && !q[i].s1_rdy && (q[i].s1_tag == cdb_tag)) begin
                woke[i].s1_rdy = 1'b1;
                woke[i].s1_val = cdb_data;
            end
            if (cdb_valid && !q[i].s2_rdy && (q[i].s2_tag == cdb_tag)) begin
                woke[i].s2_rdy = 1'b1;
                woke[i].s2_val = cdb_data;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            nxt[i] = woke[i];
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (fire && (IDX_W'(i) >= sel)) begin
                nxt[i] = woke[i + 1];
            end
        end
        if (fire) begin
            nxt[DEPTH - 1] = '0;
        end
        base    = cnt - {{(CNT_W - 1){1'b0}}, fire};
        cnt_nxt = base + {{(CNT_W - 1){1'b0}}, alloc_ok};
        for (int i = 0; i < DEPTH; i++) begin
            if (alloc_ok && (CNT_W'(i) == base)) begin
                nxt[i] = new_entry;
            end
        end
        if (RSBRA_rollback) begin
            for (int i = 0; i < DEPTH; i++) begin
                nxt[i].vld = 1'b0;
            end
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
        end else begin
            cnt <= cnt_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= nxt[i];
            end
        end
    end

`ifdef RS_BRANCH_STATS_EN
    logic [31:0] full_cycles_q;
    logic [31:0] issued_q;

    // Counters survive rollback on purpose; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_cycles_q <= '0;
            issued_q      <= '0;
        end else begin
            full_cycles_q <= full_cycles_q + {31'd0, RSBRA_full};
            issued_q      <= issued_q + {31'd0, fire};
        end
    end

    assign stat_full_cycles = full_cycles_q;
    assign stat_issued      = issued_q;
`else
    assign stat_full_cycles = '0;
    assign stat_issued      = '0;
`endif

endmodule

// File: tb/tb_rs_branch.sv
// Scoreboard bench for rs_branch: stimulus pushes expected issues, a negedge monitor pops and compares on each fire.
module tb_rs_branch;

    logic        clk;
    logic        rst_n;
    logic        alloc_valid;
    logic [3:0]  alloc_op;
    logic [4:0]  alloc_rob;
    logic [31:0] alloc_pc;
    logic [31:0] alloc_imm;
    logic [5:0]  alloc_s1_tag;
    logic [5:0]  alloc_s2_tag;
    logic        alloc_s1_rdy;
    logic        alloc_s2_rdy;
    logic [31:0] alloc_s1_val;
    logic [31:0] alloc_s2_val;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        issue_ready;
    logic        issue_valid;
    logic [3:0]  issue_op;
    logic [4:0]  issue_rob;
    logic [31:0] issue_pc;
    logic [31:0] issue_imm;
    logic [31:0] issue_s1;
    logic [31:0] issue_s2;
    logic        RSBRA_full;
    logic        RSBRA_rollback;
    logic [31:0] stat_full_cycles;
    logic [31:0] stat_issued;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rob;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] s1;
        logic [31:0] s2;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    rs_branch dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_op(alloc_op), .alloc_rob(alloc_rob),
        .alloc_pc(alloc_pc), .alloc_imm(alloc_imm),
        .alloc_s1_tag(alloc_s1_tag), .alloc_s2_tag(alloc_s2_tag),
        .alloc_s1_rdy(alloc_s1_rdy), .alloc_s2_rdy(alloc_s2_rdy),
        .alloc_s1_val(alloc_s1_val), .alloc_s2_val(alloc_s2_val),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .issue_ready(issue_ready), .issue_valid(issue_valid),
        .issue_op(issue_op), .issue_rob(issue_rob), .issue_pc(issue_pc),
        .issue_imm(issue_imm), .issue_s1(issue_s1), .issue_s2(issue_s2),
        .RSBRA_full(RSBRA_full), .RSBRA_rollback(RSBRA_rollback),
        .stat_full_cycles(stat_full_cycles), .stat_issued(stat_issued)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid    = 1'b0;
        alloc_op       = '0;
        alloc_rob      = '0;
        alloc_pc       = '0;
        alloc_imm      = '0;
        alloc_s1_tag   = '0;
        alloc_s2_tag   = '0;
        alloc_s1_rdy   = 1'b0;
        alloc_s2_rdy   = 1'b0;
        alloc_s1_val   = '0;
        alloc_s2_val   = '0;
        cdb_valid      = 1'b0;
        cdb_tag        = '0;
        cdb_data       = '0;
        RSBRA_rollback = 1'b0;
    endtask

    task automatic alloc(input logic [3:0] op, input logic [4:0] rob, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [5:0] t1, input logic r1,
                         input logic [31:0] v1, input logic [5:0] t2, input logic r2,
                         input logic [31:0] v2);
        alloc_valid  = 1'b1;
        alloc_op     = op;
        alloc_rob    = rob;
        alloc_pc     = pc;
        alloc_imm    = imm;
        alloc_s1_tag = t1;
        alloc_s1_rdy = r1;
        alloc_s1_val = v1;
        alloc_s2_tag = t2;
        alloc_s2_rdy = r2;
        alloc_s2_val = v2;
    endtask

    task automatic expect_issue(input logic [3:0] op, input logic [4:0] rob, input logic [31:0] pc,
                                input logic [31:0] imm, input logic [31:0] s1, input logic [31:0] s2);
        exp_t e;
        e.op  = op;
        e.rob = rob;
        e.pc  = pc;
        e.imm = imm;
        e.s1  = s1;
        e.s2  = s2;
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted issue must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && issue_valid && issue_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_issue: got pc 0x%0h, expected no issue", issue_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("issue_pc",  issue_pc,           e.pc);
                check("issue_rob", {27'd0, issue_rob}, {27'd0, e.rob});
                check("issue_op",  {28'd0, issue_op},  {28'd0, e.op});
                check("issue_imm", issue_imm,          e.imm);
                check("issue_s1",  issue_s1,           e.s1);
                check("issue_s2",  issue_s2,           e.s2);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n       = 1'b0;
        issue_ready = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("reset_issue_valid", {31'd0, issue_valid}, 32'd0);
        check("reset_full",        {31'd0, RSBRA_full},  32'd0);
        check("reset_stat_full",   stat_full_cycles,     32'd0);
        check("reset_stat_issued", stat_issued,          32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Ready entry issues the cycle after allocation.
        alloc(4'h1, 5'd1, 32'h100, 32'h8, 6'd1, 1'b1, 32'h11, 6'd2, 1'b1, 32'h22);
        expect_issue(4'h1, 5'd1, 32'h100, 32'h8, 32'h11, 32'h22);
        step();
        idle();
        check("t1_issue_valid", {31'd0, issue_valid}, 32'd1);
        check("t1_issue_pc",    issue_pc,             32'h100);
        step();
        check("t1_drained_valid", {31'd0, issue_valid}, 32'd0);
        check("t1_drained_full",  {31'd0, RSBRA_full},  32'd0);

        // Fill with entries waiting on tag 7.
        for (int k = 0; k < 4; k++) begin
            alloc(4'h2, 5'(4 + k), 32'h200 + 32'(4 * k), 32'h10, 6'd7, 1'b0, 32'h0,
                  6'd8, 1'b1, 32'h40 + 32'(k));
            step();
            idle();
            check("t2_full_after_alloc", {31'd0, RSBRA_full}, (k == 3) ? 32'd1 : 32'd0);
        end
        alloc(4'h3, 5'd20, 32'h300, 32'h0, 6'd1, 1'b1, 32'h1, 6'd2, 1'b1, 32'h2);
        step();
        idle();
        check("t2_full_hold",       {31'd0, RSBRA_full},  32'd1);
        check("t2_no_issue",        {31'd0, issue_valid}, 32'd0);

        // Single broadcast wakes all four; they drain oldest first.
        for (int k = 0; k < 4; k++) begin
            expect_issue(4'h2, 5'(4 + k), 32'h200 + 32'(4 * k), 32'h10, 32'hDEAD, 32'h40 + 32'(k));
        end
        cdb_valid = 1'b1;
        cdb_tag   = 6'd7;
        cdb_data  = 32'hDEAD;
        step();
        idle();
        check("t3_wake_valid", {31'd0, issue_valid}, 32'd1);
        check("t3_wake_pc",    issue_pc,             32'h200);
        check("t3_full_before_fire", {31'd0, RSBRA_full}, 32'd1);
        step();
        check("t3_full_after_fire", {31'd0, RSBRA_full}, 32'd0);
        repeat (3) step();
        check("t3_drained", {31'd0, issue_valid}, 32'd0);
`ifdef RS_BRANCH_STATS_EN
        check("t3_stat_full",   stat_full_cycles, 32'd3);
        check("t3_stat_issued", stat_issued,      32'd5);
`else
        check("t3_stat_full",   stat_full_cycles, 32'd0);
        check("t3_stat_issued", stat_issued,      32'd0);
`endif

        // Dispatch-time CDB bypass on source 2.
        alloc(4'h4, 5'd9, 32'h400, 32'h4, 6'd1, 1'b1, 32'h1, 6'd9, 1'b0, 32'h0);
        cdb_valid = 1'b1;
        cdb_tag   = 6'd9;
        cdb_data  = 32'h55;
        expect_issue(4'h4, 5'd9, 32'h400, 32'h4, 32'h1, 32'h55);
        step();
        idle();
        check("t4_bypass_valid", {31'd0, issue_valid}, 32'd1);
        check("t4_bypass_s2",    issue_s2,             32'h55);
        step();
        check("t4_drained", {31'd0, issue_valid}, 32'd0);

        // Younger ready entry bypasses an older blocked one; held while not accepted.
        issue_ready = 1'b0;
        alloc(4'h5, 5'd10, 32'h500, 32'h0, 6'd3, 1'b0, 32'h0, 6'd2, 1'b1, 32'h2);
        step();
        alloc(4'h6, 5'd11, 32'h504, 32'h0, 6'd1, 1'b1, 32'hB1, 6'd2, 1'b1, 32'hB2);
        step();
        idle();
        check("t5_b_valid", {31'd0, issue_valid}, 32'd1);
        check("t5_b_pc",    issue_pc,             32'h504);
        step();
        check("t5_b_held_pc", issue_pc, 32'h504);
        expect_issue(4'h6, 5'd11, 32'h504, 32'h0, 32'hB1, 32'hB2);
        issue_ready = 1'b1;
        step();
        check("t5_a_blocked", {31'd0, issue_valid}, 32'd0);
        expect_issue(4'h5, 5'd10, 32'h500, 32'h0, 32'h33, 32'h2);
        cdb_valid = 1'b1;
        cdb_tag   = 6'd3;
        cdb_data  = 32'h33;
        step();
        idle();
        check("t5_a_valid", {31'd0, issue_valid}, 32'd1);
        check("t5_a_pc",    issue_pc,             32'h500);
        step();
        check("t5_drained", {31'd0, issue_valid}, 32'd0);

        // Rollback with a concurrent alloc empties the station.
        issue_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            alloc(4'h7, 5'(24 + k), 32'h600 + 32'(4 * k), 32'h0, 6'd12, 1'b0, 32'h0,
                  6'd2, 1'b1, 32'h2);
            step();
        end
        idle();
        check("t6_pre_full", {31'd0, RSBRA_full}, 32'd0);
        alloc(4'h8, 5'd30, 32'h700, 32'h0, 6'd1, 1'b1, 32'h1, 6'd2, 1'b1, 32'h2);
        RSBRA_rollback = 1'b1;
        step();
        idle();
        check("t6_rb_valid", {31'd0, issue_valid}, 32'd0);
        check("t6_rb_full",  {31'd0, RSBRA_full},  32'd0);
        alloc(4'h9, 5'd31, 32'h800, 32'h0, 6'd13, 1'b0, 32'h0, 6'd2, 1'b1, 32'h2);
        cdb_valid = 1'b1;
        cdb_tag   = 6'd12;
        cdb_data  = 32'hC;
        step();
        idle();
        check("t6_cnt_cleared_full", {31'd0, RSBRA_full}, 32'd0);
        step();
        check("t6_no_stale_wake", {31'd0, issue_valid}, 32'd0);
`ifdef RS_BRANCH_STATS_EN
        check("t6_stat_issued", stat_issued,      32'd8);
        check("t6_stat_full",   stat_full_cycles, 32'd3);
`else
        check("t6_stat_issued", stat_issued,      32'd0);
        check("t6_stat_full",   stat_full_cycles, 32'd0);
`endif
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
